// File: rtl/bus_trace_buffer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bus_trace_buffer : circular CPU bus trace with addr/rw trigger and
// oldest-first readout. Define TRACE_TIMESTAMP_EN to prepend a 32-bit stamp.
// Rev 1.0
// ---------------------------------------------------------------------------
module bus_trace_buffer #(
  parameter int AW    = 32,
  parameter int DW    = 8,
  parameter int SW    = 6,
  parameter int DEPTH = 1024,
  parameter int PTW   = $clog2(DEPTH),
`ifdef TRACE_TIMESTAMP_EN
  parameter int EW    = 32 + 1 + SW + AW + DW
`else
  parameter int EW    = 1 + SW + AW + DW
`endif
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           bus_rw,
  input  logic [SW-1:0]  bus_state,
  input  logic [AW-1:0]  bus_ad,
  input  logic [DW-1:0]  bus_db,
  input  logic           arm,
  input  logic           mode_all,
  input  logic [AW-1:0]  trig_addr,
  input  logic [AW-1:0]  trig_mask,
  input  logic           trig_rw_en,
  input  logic           trig_rw,
  input  logic           force_trig,
  input  logic [PTW-1:0] post_cnt,
  input  logic [PTW-1:0] rd_idx,
  output logic [EW-1:0]  rd_data,
  output logic           armed,
  output logic           triggered,
  output logic           done,
  output logic [PTW:0]   count,
  output logic [PTW-1:0] trig_pos
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_POST  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [PTW:0] FULL = (PTW+1)'(DEPTH);

  logic [1:0]     state_q, state_d;
  logic [PTW-1:0] wr_ptr_q;
  logic [PTW:0]   count_q;
  logic           first_q;
  logic [SW-1:0]  prev_state_q;
  logic [AW-1:0]  prev_ad_q;
  logic           force_q;
  logic           triggered_q;
  logic [PTW-1:0] trig_wr_q;
  logic [PTW-1:0] post_q;
  logic [EW-1:0]  rd_data_q;
  logic [EW-1:0]  mem [DEPTH];

  logic           w_capturing;
  logic           w_cap;
  logic           w_match;
  logic           w_hit;
  logic [PTW-1:0] w_oldest;
  logic [PTW-1:0] w_rd_addr;
  logic [EW-1:0]  w_entry;

`ifdef TRACE_TIMESTAMP_EN
  logic [31:0] ts_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ts_q <= '0;
    else        ts_q <= ts_q + 32'd1;
  end

  assign w_entry = {ts_q, bus_rw, bus_state, bus_ad, bus_db};
`else
  assign w_entry = {bus_rw, bus_state, bus_ad, bus_db};
`endif

  // arm suppresses the same-cycle capture so the restart always begins clean
  always_comb begin
    w_capturing = (state_q == S_ARMED) || (state_q == S_POST);
    w_cap       = w_capturing && !arm &&
                  (mode_all || first_q || (bus_state != prev_state_q) || (bus_ad != prev_ad_q));
    w_match     = (((bus_ad ^ trig_addr) & trig_mask) == '0) &&
                  (!trig_rw_en || (bus_rw == trig_rw));
    w_hit       = (state_q == S_ARMED) && w_cap && (force_q || force_trig || w_match);
    w_oldest    = (count_q == FULL) ? wr_ptr_q : '0;
    w_rd_addr   = w_oldest + rd_idx;
  end

  always_comb begin
    state_d = state_q;
    if (arm)
      state_d = S_ARMED;
    else if (w_hit)
      state_d = (post_cnt == '0) ? S_DONE : S_POST;
    else if ((state_q == S_POST) && w_cap && (post_q == PTW'(1)))
      state_d = S_DONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      first_q      <= 1'b1;
      prev_state_q <= '0;
      prev_ad_q    <= '0;
      force_q      <= 1'b0;
      triggered_q  <= 1'b0;
      trig_wr_q    <= '0;
      post_q       <= '0;
    end else begin
      state_q      <= state_d;
      prev_state_q <= bus_state;
      prev_ad_q    <= bus_ad;
      if (arm) begin
        wr_ptr_q    <= '0;
        count_q     <= '0;
        first_q     <= 1'b1;
        force_q     <= 1'b0;
        triggered_q <= 1'b0;
      end else begin
        if (w_cap) begin
          wr_ptr_q <= wr_ptr_q + PTW'(1);
          first_q  <= 1'b0;
          if (count_q != FULL) count_q <= count_q + (PTW+1)'(1);
        end
        // post_cnt is PTW bits wide, so it can never exceed DEPTH-1
        if (w_hit) begin
          triggered_q <= 1'b1;
          trig_wr_q   <= wr_ptr_q;
          post_q      <= post_cnt;
          force_q     <= 1'b0;
        end else begin
          if (force_trig) force_q <= 1'b1;
          if ((state_q == S_POST) && w_cap) post_q <= post_q - PTW'(1);
        end
      end
    end
  end

  // RAM kept free of reset so it maps onto block memory
  always_ff @(posedge clk) begin
    if (w_cap) mem[wr_ptr_q] <= w_entry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data_q <= '0;
    else        rd_data_q <= mem[w_rd_addr];
  end

  assign rd_data   = rd_data_q;
  assign armed     = w_capturing;
  assign triggered = triggered_q;
  assign done      = (state_q == S_DONE);
  assign count     = count_q;
  assign trig_pos  = triggered_q ? (trig_wr_q - w_oldest) : '0;

endmodule
`default_nettype wire

// File: tb/tb_bus_trace_buffer.sv
`default_nettype none
// tb_bus_trace_buffer : directed stimulus with a queue-based reference model
// checked every cycle, plus hand-computed literal expectations.
module tb_bus_trace_buffer;

  localparam int AW = 32, DW = 8, SW = 6, DEPTH = 16, PTW = 4;
  localparam int BW = 1 + SW + AW + DW;
`ifdef TRACE_TIMESTAMP_EN
  localparam int EW = 32 + BW;
`else
  localparam int EW = BW;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           bus_rw = 1'b0;
  logic [SW-1:0]  bus_state = '0;
  logic [AW-1:0]  bus_ad = '0;
  logic [DW-1:0]  bus_db = '0;
  logic           arm = 1'b0;
  logic           mode_all = 1'b0;
  logic [AW-1:0]  trig_addr = '0;
  logic [AW-1:0]  trig_mask = '0;
  logic           trig_rw_en = 1'b0;
  logic           trig_rw = 1'b0;
  logic           force_trig = 1'b0;
  logic [PTW-1:0] post_cnt = '0;
  logic [PTW-1:0] rd_idx = '0;
  logic [EW-1:0]  rd_data;
  logic           armed, triggered, done;
  logic [PTW:0]   count;
  logic [PTW-1:0] trig_pos;

  bus_trace_buffer #(.AW(AW), .DW(DW), .SW(SW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .bus_rw(bus_rw), .bus_state(bus_state),
    .bus_ad(bus_ad), .bus_db(bus_db), .arm(arm), .mode_all(mode_all),
    .trig_addr(trig_addr), .trig_mask(trig_mask), .trig_rw_en(trig_rw_en),
    .trig_rw(trig_rw), .force_trig(force_trig), .post_cnt(post_cnt),
    .rd_idx(rd_idx), .rd_data(rd_data), .armed(armed), .triggered(triggered),
    .done(done), .count(count), .trig_pos(trig_pos)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the trace is a queue of at most DEPTH entries, oldest first
  logic [BW-1:0] m_q[$];
  bit            m_on, m_done, m_trig, m_first, m_force, model_live;
  int            m_post_left, m_total, m_trig_num;
  logic [SW-1:0] m_prev_st;
  logic [AW-1:0] m_prev_ad;
  bit            exp_rd_ok;
  logic [BW-1:0] exp_rd;

  always @(posedge clk) begin
    bit chg, hit;
    model_live = 1'b1;
    if (!rst_n) begin
      m_q.delete();
      m_on = 0; m_done = 0; m_trig = 0; m_first = 1; m_force = 0;
      m_post_left = -1; m_total = 0; m_trig_num = 0;
      m_prev_st = '0; m_prev_ad = '0;
      exp_rd_ok = 1; exp_rd = '0;
    end else begin
      exp_rd_ok = int'(rd_idx) < m_q.size();
      if (exp_rd_ok) exp_rd = m_q[rd_idx];
      if (arm) begin
        m_q.delete();
        m_on = 1; m_done = 0; m_trig = 0; m_first = 1; m_force = 0;
        m_post_left = -1; m_total = 0;
      end else begin
        if (force_trig) m_force = 1;
        chg = mode_all || m_first || (bus_state != m_prev_st) || (bus_ad != m_prev_ad);
        if (m_on && chg) begin
          m_q.push_back({bus_rw, bus_state, bus_ad, bus_db});
          if (m_q.size() > DEPTH) void'(m_q.pop_front());
          m_first = 0;
          m_total++;
          if (m_post_left < 0) begin
            hit = m_force || ((((bus_ad ^ trig_addr) & trig_mask) == '0) &&
                              (!trig_rw_en || bus_rw == trig_rw));
            if (hit) begin
              m_trig = 1; m_force = 0; m_trig_num = m_total - 1;
              if (post_cnt == 0) begin m_on = 0; m_done = 1; end
              else m_post_left = int'(post_cnt);
            end
          end else begin
            m_post_left--;
            if (m_post_left == 0) begin m_on = 0; m_done = 1; m_post_left = -1; end
          end
        end
      end
      m_prev_st = bus_state;
      m_prev_ad = bus_ad;
    end
  end

  always @(negedge clk) begin
    if (model_live) begin
      chk("armed", 64'(armed), 64'(m_on));
      chk("done", 64'(done), 64'(m_done));
      chk("triggered", 64'(triggered), 64'(m_trig));
      chk("count", 64'(count), 64'(m_q.size()));
      chk("trig_pos", 64'(trig_pos),
          m_trig ? 64'(m_trig_num - (m_total - m_q.size())) : 64'd0);
      if (exp_rd_ok) chk("rd_data", 64'(rd_data[BW-1:0]), 64'(exp_rd));
    end
  end

  task automatic step();
    rd_idx = rd_idx + 4'd5;
    @(negedge clk);
  endtask

  task automatic do_arm();
    arm = 1'b1;
    step();
    arm = 1'b0;
  endtask

  task automatic read_ad(input int idx, output logic [AW-1:0] ad);
    rd_idx = PTW'(idx);
    @(negedge clk);
    ad = rd_data[DW +: AW];
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [AW-1:0] ad;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_rd_data", 64'(rd_data), 64'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus_ad = AW'(i * 7); bus_state = SW'(i); bus_rw = i[0]; bus_db = DW'(i);
      step();
    end
    chk("idle_count", 64'(count), 64'd0);
    chk("idle_armed", 64'(armed), 64'd0);

    // change-only capture
    mode_all = 0; trig_addr = 32'hDEAD0000; trig_mask = '1; post_cnt = 0;
    bus_state = 6'h05; bus_rw = 1; bus_ad = 32'hFFFC;
    do_arm();
    repeat (5) step();
    bus_ad = 32'hFFFD; step();
    bus_ad = 32'h0400; step();
    step();
    chk("chg_count", 64'(count), 64'd3);
    read_ad(0, ad); chk("chg_rd0", 64'(ad), 64'hFFFC);
    read_ad(1, ad); chk("chg_rd1", 64'(ad), 64'hFFFD);
    read_ad(2, ad); chk("chg_rd2", 64'(ad), 64'h0400);

    // trigger with post
    mode_all = 1; trig_addr = 32'h0010; post_cnt = 4; bus_ad = 0;
    do_arm();
    for (int i = 0; i < 25; i++) begin
      bus_ad = AW'(i); bus_state = SW'(i); bus_db = DW'(i * 3); bus_rw = i[1];
      step();
    end
    chk("post_done", 64'(done), 64'd1);
    chk("post_count", 64'(count), 64'd16);
    chk("post_trig_pos", 64'(trig_pos), 64'd11);
    read_ad(0, ad); chk("post_rd0", 64'(ad), 64'h05);
    read_ad(15, ad); chk("post_rd15", 64'(ad), 64'h14);

    // rw qualifier
    trig_addr = 32'h0200; trig_rw_en = 1; trig_rw = 0; post_cnt = 2;
    bus_ad = 32'h0100; bus_rw = 1;
    do_arm();
    step();
    bus_ad = 32'h0200; bus_rw = 1; step();
    chk("rw_read_notrig", 64'(triggered), 64'd0);
    bus_ad = 32'h0200; bus_rw = 0; step();
    chk("rw_write_trig", 64'(triggered), 64'd1);
    bus_ad = 32'h0300; step(); step();
    chk("rw_done", 64'(done), 64'd1);

    // force and wrap
    trig_addr = 32'hFFFF0000; trig_rw_en = 0; post_cnt = 0; bus_ad = 32'h0FFF;
    do_arm();
    for (int i = 0; i < 40; i++) begin
      bus_ad = 32'h1000 + AW'(i); step();
    end
    mode_all = 0; force_trig = 1; step();
    force_trig = 0;
    chk("force_pending", 64'(triggered), 64'd0);
    bus_ad = 32'h2000; step();
    chk("force_done", 64'(done), 64'd1);
    chk("force_count", 64'(count), 64'd16);
    chk("force_trig_pos", 64'(trig_pos), 64'd15);
    read_ad(0, ad); chk("force_rd0", 64'(ad), 64'h1019);
    read_ad(15, ad); chk("force_rd15", 64'(ad), 64'h2000);

    // re-arm during POST with an address match, then during ARMED
    mode_all = 1; trig_addr = 32'h0050; post_cnt = 5; bus_ad = 32'h40;
    do_arm();
    for (int i = 'h40; i <= 'h52; i++) begin
      bus_ad = AW'(i); step();
    end
    chk("rearm_pre_trig", 64'(triggered), 64'd1);
    bus_ad = 32'h50;
    do_arm();
    chk("rearm_trig", 64'(triggered), 64'd0);
    chk("rearm_count", 64'(count), 64'd0);
    chk("rearm_armed", 64'(armed), 64'd1);
    bus_ad = 32'h77; step();
    chk("rearm_count1", 64'(count), 64'd1);
    read_ad(0, ad); chk("rearm_rd0", 64'(ad), 64'h77);
    bus_ad = 32'h50;
    do_arm();
    chk("arm_wins_trig", 64'(triggered), 64'd0);
    chk("arm_wins_count", 64'(count), 64'd0);
    bus_ad = 32'h60; step(); step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
